// File: rtl/keccak_pkg.sv
// Shared Keccak widths, mode encodings and arbiter state type.
package keccak_pkg;

  localparam int unsigned DWIDTH            = 64;
  localparam int unsigned KEEP_WIDTH        = DWIDTH / 8;
  localparam int unsigned MAX_OUTPUT_DWIDTH = 256;
  localparam int unsigned MODE_SEL_WIDTH    = 2;
  localparam int unsigned NUM_KECCAK_REQ    = 4;

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_224 = 2'd0;
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = 2'd1;
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_384 = 2'd2;
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = 2'd3;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_START   = 3'd1,
    ARB_ABSORB  = 3'd2,
    ARB_SQUEEZE = 3'd3,
    ARB_RELEASE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping.
module keccak_rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                any_valid,
  output logic [ID_WIDTH-1:0] winner
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        off;
  logic [ID_WIDTH-1:0] src;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot       = '0;
    off       = 0;
    any_valid = 1'b0;
    src       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src    = ID_WIDTH'((i + 32'(ptr)) % NUM_REQ);
      rot[i] = req[src];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && rot[i]) begin
        any_valid = 1'b1;
        off       = i;
      end
    end
    winner = ID_WIDTH'((off + 32'(ptr)) % NUM_REQ);
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Round-robin owner of a single keccak_core: one full start/absorb/squeeze
// transaction per grant, with the core's streams routed to the owner only.
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_KECCAK_REQ,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_i,
  input  logic [NUM_REQ-1:0][MODE_SEL_WIDTH-1:0]      mode_i,
  output logic [NUM_REQ-1:0]                          gnt_o,
  output logic                                        busy_o,
  output logic [ID_WIDTH-1:0]                         owner_o,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0]              s_data_i,
  input  logic [NUM_REQ-1:0]                          s_valid_i,
  input  logic [NUM_REQ-1:0]                          s_last_i,
  input  logic [NUM_REQ-1:0][KEEP_WIDTH-1:0]          s_keep_i,
  output logic [NUM_REQ-1:0]                          s_ready_o,
  output logic [NUM_REQ-1:0][MAX_OUTPUT_DWIDTH-1:0]   m_data_o,
  output logic [NUM_REQ-1:0]                          m_valid_o,
  output logic [NUM_REQ-1:0]                          m_last_o,
  input  logic [NUM_REQ-1:0]                          m_ready_i,
  output logic                                        core_start_o,
  output logic [MODE_SEL_WIDTH-1:0]                   core_mode_o,
  output logic [DWIDTH-1:0]                           core_t_data_o,
  output logic                                        core_t_valid_o,
  output logic                                        core_t_last_o,
  output logic [KEEP_WIDTH-1:0]                       core_t_keep_o,
  input  logic                                        core_t_ready_i,
  input  logic [MAX_OUTPUT_DWIDTH-1:0]                core_t_data_i,
  input  logic                                        core_t_valid_i,
  input  logic                                        core_t_last_i,
  output logic                                        core_t_ready_o
);

  arb_state_t                state;
  logic [ID_WIDTH-1:0]       owner;
  logic [ID_WIDTH-1:0]       rr_ptr;
  logic [MODE_SEL_WIDTH-1:0] mode_q;

  logic                      any_valid;
  logic [ID_WIDTH-1:0]       winner;
  logic                      absorb_done;
  logic                      squeeze_done;

  keccak_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req       (req_i),
    .ptr       (rr_ptr),
    .any_valid (any_valid),
    .winner    (winner)
  );

  assign absorb_done  = s_valid_i[owner] & core_t_ready_i & s_last_i[owner];
  assign squeeze_done = core_t_valid_i & m_ready_i[owner] & core_t_last_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      mode_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            owner  <= winner;
            mode_q <= mode_i[winner];
            state  <= ARB_START;
          end
        end
        ARB_START:   state <= ARB_ABSORB;
        ARB_ABSORB:  if (absorb_done)  state <= ARB_SQUEEZE;
        ARB_SQUEEZE: if (squeeze_done) state <= ARB_RELEASE;
        ARB_RELEASE: begin
          rr_ptr <= ID_WIDTH'((32'(owner) + 32'd1) % NUM_REQ);
          state  <= ARB_IDLE;
        end
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  assign owner_o     = owner;
  assign core_mode_o = mode_q;

  // Pure routing: every stream output is a mux of the owner's live handshake.
  always_comb begin
    gnt_o          = '0;
    busy_o         = 1'b0;
    s_ready_o      = '0;
    m_data_o       = '0;
    m_valid_o      = '0;
    m_last_o       = '0;
    core_start_o   = 1'b0;
    core_t_data_o  = '0;
    core_t_valid_o = 1'b0;
    core_t_last_o  = 1'b0;
    core_t_keep_o  = '0;
    core_t_ready_o = 1'b0;
    case (state)
      ARB_START: begin
        gnt_o[owner] = 1'b1;
        busy_o       = 1'b1;
        core_start_o = 1'b1;
      end
      ARB_ABSORB: begin
        gnt_o[owner]     = 1'b1;
        busy_o           = 1'b1;
        core_t_data_o    = s_data_i[owner];
        core_t_keep_o    = s_keep_i[owner];
        core_t_valid_o   = s_valid_i[owner];
        core_t_last_o    = s_last_i[owner] & s_valid_i[owner];
        s_ready_o[owner] = core_t_ready_i;
      end
      ARB_SQUEEZE: begin
        gnt_o[owner]     = 1'b1;
        busy_o           = 1'b1;
        m_data_o[owner]  = core_t_data_i;
        m_valid_o[owner] = core_t_valid_i;
        m_last_o[owner]  = core_t_last_i;
        core_t_ready_o   = m_ready_i[owner];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter; the bench itself plays the keccak_core.
module tb_keccak_arbiter;
  import keccak_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic [N-1:0]                         req_i;
  logic [N-1:0][MODE_SEL_WIDTH-1:0]     mode_i;
  logic [N-1:0]                         gnt_o;
  logic                                 busy_o;
  logic [IDW-1:0]                       owner_o;
  logic [N-1:0][DWIDTH-1:0]             s_data_i;
  logic [N-1:0]                         s_valid_i;
  logic [N-1:0]                         s_last_i;
  logic [N-1:0][KEEP_WIDTH-1:0]         s_keep_i;
  logic [N-1:0]                         s_ready_o;
  logic [N-1:0][MAX_OUTPUT_DWIDTH-1:0]  m_data_o;
  logic [N-1:0]                         m_valid_o;
  logic [N-1:0]                         m_last_o;
  logic [N-1:0]                         m_ready_i;
  logic                                 core_start_o;
  logic [MODE_SEL_WIDTH-1:0]            core_mode_o;
  logic [DWIDTH-1:0]                    core_t_data_o;
  logic                                 core_t_valid_o;
  logic                                 core_t_last_o;
  logic [KEEP_WIDTH-1:0]                core_t_keep_o;
  logic                                 core_t_ready_i;
  logic [MAX_OUTPUT_DWIDTH-1:0]         core_t_data_i;
  logic                                 core_t_valid_i;
  logic                                 core_t_last_i;
  logic                                 core_t_ready_o;

  keccak_arbiter #(
    .NUM_REQ  (N),
    .ID_WIDTH (IDW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .mode_i         (mode_i),
    .gnt_o          (gnt_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_last_i       (s_last_i),
    .s_keep_i       (s_keep_i),
    .s_ready_o      (s_ready_o),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_last_o       (m_last_o),
    .m_ready_i      (m_ready_i),
    .core_start_o   (core_start_o),
    .core_mode_o    (core_mode_o),
    .core_t_data_o  (core_t_data_o),
    .core_t_valid_o (core_t_valid_o),
    .core_t_last_o  (core_t_last_o),
    .core_t_keep_o  (core_t_keep_o),
    .core_t_ready_i (core_t_ready_i),
    .core_t_data_i  (core_t_data_i),
    .core_t_valid_i (core_t_valid_i),
    .core_t_last_i  (core_t_last_i),
    .core_t_ready_o (core_t_ready_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_i          = '0;
    mode_i         = '0;
    s_data_i       = '0;
    s_valid_i      = '0;
    s_last_i       = '0;
    s_keep_i       = '0;
    m_ready_i      = '1;
    core_t_ready_i = 1'b0;
    core_t_data_i  = '0;
    core_t_valid_i = 1'b0;
    core_t_last_i  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},    gnt_o, '0);
    chk({tag, "_busy"},   busy_o, '0);
    chk({tag, "_owner"},  owner_o, '0);
    chk({tag, "_start"},  core_start_o, '0);
    chk({tag, "_mode"},   core_mode_o, '0);
    chk({tag, "_sready"}, s_ready_o, '0);
    chk({tag, "_mvalid"}, {m_valid_o, m_last_o}, '0);
    chk({tag, "_mdata"},  m_data_o[1] | m_data_o[2], '0);
    chk({tag, "_ctv"},    {core_t_valid_o, core_t_last_o, core_t_ready_o}, '0);
    chk({tag, "_ctdata"}, {core_t_data_o, core_t_keep_o}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One full transaction driven from IDLE with the owner's request already up.
  // Returns in IDLE after checking the RELEASE/IDLE gap.
  task automatic do_txn(input int unsigned own, input logic [1:0] mode,
                        input int unsigned n_in, input int unsigned bp, input bit drop_req);
    logic [N-1:0]       oh;
    logic [DWIDTH-1:0]  din;
    logic [255:0]       dig;
    oh          = N'(1) << own;
    mode_i[own] = mode;
    tick();
    chk("start_gnt",   gnt_o, oh);
    chk("start_busy",  busy_o, 1'b1);
    chk("start_owner", owner_o, own);
    chk("start_pulse", core_start_o, 1'b1);
    chk("start_mode",  core_mode_o, mode);
    if (drop_req) req_i[own] = 1'b0;
    mode_i[own] = ~mode;
    tick();
    chk("abs_start_low", core_start_o, 1'b0);
    chk("abs_gnt",       gnt_o, oh);
    chk("abs_mode_held", core_mode_o, mode);
    s_valid_i[own] = 1'b0;
    s_last_i[own]  = 1'b1;
    core_t_ready_i = 1'b1;
    #1;
    chk("stray_last",  {core_t_valid_o, core_t_last_o}, 2'b00);
    chk("abs_sready",  s_ready_o, oh);
    tick();
    for (int unsigned b = 0; b < n_in; b++) begin
      din            = {32'(own), 32'(b)} ^ 64'hC0DE_0000_0000_BEEF;
      s_data_i[own]  = din;
      s_valid_i[own] = 1'b1;
      s_last_i[own]  = (b == n_in - 1);
      s_keep_i[own]  = (b == n_in - 1) ? 8'h0F : 8'hFF;
      #1;
      chk("abs_valid",  core_t_valid_o, 1'b1);
      chk("abs_data",   core_t_data_o, din);
      chk("abs_keep",   core_t_keep_o, (b == n_in - 1) ? 8'h0F : 8'hFF);
      chk("abs_last",   core_t_last_o, (b == n_in - 1));
      chk("abs_sready", s_ready_o, oh);
      chk("abs_ctready", core_t_ready_o, 1'b0);
      tick();
    end
    s_valid_i[own] = 1'b0;
    s_last_i[own]  = 1'b0;
    core_t_ready_i = 1'b0;
    dig            = {4{64'h0123_4567_89AB_CDEF}} ^ 256'(own + 1);
    core_t_data_i  = dig;
    core_t_valid_i = 1'b1;
    core_t_last_i  = 1'b1;
    m_ready_i[own] = 1'b0;
    #1;
    chk("sq_ctvalid_low", core_t_valid_o, 1'b0);
    chk("sq_sready_low",  s_ready_o, '0);
    for (int unsigned c = 0; c < bp; c++) begin
      chk("bp_ctready", core_t_ready_o, 1'b0);
      chk("bp_mvalid",  m_valid_o, oh);
      chk("bp_data",    m_data_o[own], dig);
      chk("bp_gnt",     gnt_o, oh);
      tick();
    end
    m_ready_i[own] = 1'b1;
    #1;
    chk("sq_ctready", core_t_ready_o, 1'b1);
    chk("sq_mvalid",  m_valid_o, oh);
    chk("sq_mlast",   m_last_o, oh);
    chk("sq_data",    m_data_o[own], dig);
    chk("sq_other",   m_data_o[(own + 1) % N], '0);
    chk("sq_mode",    core_mode_o, mode);
    tick();
    core_t_valid_i = 1'b0;
    core_t_last_i  = 1'b0;
    chk("rel_gnt",    gnt_o, '0);
    chk("rel_busy",   busy_o, 1'b0);
    chk("rel_mvalid", m_valid_o, '0);
    tick();
    chk("idle_gnt",   gnt_o, '0);
    chk("idle_start", core_start_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Single requester, owner drops req after grant; then rr_ptr=1 picks 1 over 0.
    req_i = 4'b0001;
    do_txn(0, MODE_SHA3_256, 3, 0, 1'b1);
    req_i = 4'b0011;
    do_txn(1, MODE_SHA3_512, 1, 0, 1'b0);
    req_i = '0;

    do_reset();
    req_i = 4'b0101;
    do_txn(0, MODE_SHA3_224, 2, 0, 1'b0);
    do_txn(2, MODE_SHA3_384, 2, 0, 1'b0);
    req_i = '0;

    do_reset();
    req_i = 4'b1111;
    do_txn(0, MODE_SHA3_256, 1, 0, 1'b0);
    do_txn(1, MODE_SHA3_256, 1, 0, 1'b0);
    do_txn(2, MODE_SHA3_256, 1, 0, 1'b0);
    do_txn(3, MODE_SHA3_256, 1, 0, 1'b0);
    do_txn(0, MODE_SHA3_256, 1, 0, 1'b0);
    req_i = '0;

    // rr_ptr is now 1: owner 1 with backpressure while requester 3 pushes a stray beat.
    req_i        = 4'b1010;
    s_valid_i[3] = 1'b1;
    s_last_i[3]  = 1'b1;
    s_data_i[3]  = 64'hDEAD_DEAD_DEAD_DEAD;
    s_keep_i[3]  = 8'hAA;
    do_txn(1, MODE_SHA3_384, 2, 10, 1'b0);
    s_valid_i[3] = 1'b0;
    s_last_i[3]  = 1'b0;
    do_txn(3, MODE_SHA3_512, 1, 0, 1'b0);
    req_i = '0;

    // Asynchronous reset in the middle of ABSORB.
    req_i = 4'b0010;
    mode_i[1] = MODE_SHA3_512;
    tick();
    tick();
    s_valid_i[1]   = 1'b1;
    s_data_i[1]    = 64'h1111_2222_3333_4444;
    core_t_ready_i = 1'b1;
    #1;
    chk("pre_rst_valid", core_t_valid_o, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", gnt_o, '0);
    req_i = 4'b0100;
    do_txn(2, MODE_SHA3_224, 2, 0, 1'b1);
    req_i = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
